// File: rtl/ehl_bmp_pkg.sv
// ehl_bmp_pkg
// Shared constants for the BMP stream encoder: header geometry, fixed
// header field values, signature bytes, FSM state encoding, and a helper
// that picks one byte lane out of a little-endian 32-bit word.

package ehl_bmp_pkg;

    // Header geometry
    localparam logic [5:0]  HDR_LEN    = 6'd54;
    localparam logic [5:0]  HDR_LAST   = 6'd53;

    // Fixed header field values
    localparam logic [31:0] PIX_OFFSET = 32'd54;
    localparam logic [31:0] DIB_SIZE   = 32'd40;
    localparam logic [31:0] PPM        = 32'd3779;

    // Signature bytes
    localparam logic [7:0]  SIG_B      = 8'h42;
    localparam logic [7:0]  SIG_M      = 8'h4D;

    // Byte offsets of the header fields. Planes and bpp are two adjacent
    // 16-bit fields and are treated as one 32-bit word starting at
    // OFS_PLANES, so every field after the signature is 4 bytes wide.
    localparam logic [5:0]  OFS_FSIZE   = 6'd2;
    localparam logic [5:0]  OFS_RSVD    = 6'd6;
    localparam logic [5:0]  OFS_OFFBITS = 6'd10;
    localparam logic [5:0]  OFS_DIBSZ   = 6'd14;
    localparam logic [5:0]  OFS_WIDTH   = 6'd18;
    localparam logic [5:0]  OFS_HEIGHT  = 6'd22;
    localparam logic [5:0]  OFS_PLANES  = 6'd26;
    localparam logic [5:0]  OFS_COMPR   = 6'd30;
    localparam logic [5:0]  OFS_ISIZE   = 6'd34;
    localparam logic [5:0]  OFS_XPPM    = 6'd38;
    localparam logic [5:0]  OFS_YPPM    = 6'd42;
    localparam logic [5:0]  OFS_CLRUSED = 6'd46;

    // Encoder FSM states
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        HDR,
        PIXW,
        PIXB,
        PAD
    } state_e;

    // Little-endian lane select: lane 0 is the least significant byte
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ehl_bmp_hdr_mux.sv
// ehl_bmp_hdr_mux
// Combinational selection of one BMP header byte from the header index.
// Ports:
//   hdr_idx    in   6  header byte index 0..53
//   file_size  in  32  total file size in bytes
//   img_size   in  32  pixel array size in bytes (including row padding)
//   width      in  32  image width field
//   height     in  32  image height field (already negated for top-down)
//   bpp32      in   1  1: 32 bpp, 0: 24 bpp
//   hdr_byte   out  8  header byte at hdr_idx

module ehl_bmp_hdr_mux
    import ehl_bmp_pkg::*;
(
    input  logic [5:0]  hdr_idx,
    input  logic [31:0] file_size,
    input  logic [31:0] img_size,
    input  logic [31:0] width,
    input  logic [31:0] height,
    input  logic        bpp32,
    output logic [7:0]  hdr_byte
);

    logic [31:0] field;
    logic [1:0]  lane;

    // Pick the 32-bit field covering hdr_idx, then the byte within it.
    // Every field starts at an offset of 2 mod 4, so (idx - 2) mod 4,
    // which equals (idx + 2) mod 4, is the lane.
    always_comb begin
        lane  = hdr_idx[1:0] + 2'd2;
        field = '0;
        if (hdr_idx < OFS_RSVD)         field = file_size;
        else if (hdr_idx < OFS_OFFBITS) field = '0;
        else if (hdr_idx < OFS_DIBSZ)   field = PIX_OFFSET;
        else if (hdr_idx < OFS_WIDTH)   field = DIB_SIZE;
        else if (hdr_idx < OFS_HEIGHT)  field = width;
        else if (hdr_idx < OFS_PLANES)  field = height;
        else if (hdr_idx < OFS_COMPR)   field = {(bpp32 ? 16'd32 : 16'd24), 16'd1};
        else if (hdr_idx < OFS_ISIZE)   field = '0;
        else if (hdr_idx < OFS_XPPM)    field = img_size;
        else if (hdr_idx < OFS_YPPM)    field = PPM;
        else if (hdr_idx < OFS_CLRUSED) field = PPM;
        else                            field = '0;

        if (hdr_idx < OFS_FSIZE) hdr_byte = hdr_idx[0] ? SIG_M : SIG_B;
        else                     hdr_byte = byte_lane(field, lane);
    end

endmodule

// File: rtl/ehl_bmp_stream_enc.sv
// ehl_bmp_stream_enc
// Turns a valid/ready pixel stream into a complete BMP file on a
// valid/ready byte stream: 54-byte header, then pixels in arrival order
// as B,G,R(,A) with zero padding to a 4-byte row stride.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start, x, y, bpp32,       begin a file; config sampled with start
//   top_down
//   busy, done, err           file in progress / end pulse / reject pulse
//   pix_valid, pix_ready,     pixel input channel
//   pix_r/g/b/a
//   byte_valid, byte_ready,   byte output channel, byte_last marks the
//   byte_data, byte_last      final byte of the file

module ehl_bmp_stream_enc
    import ehl_bmp_pkg::*;
#(
    parameter int XW = 12,
    parameter int YW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          bpp32,
    input  logic          top_down,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    input  logic [7:0]    pix_a,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic [7:0]    byte_data,
    output logic          byte_last
);

    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, col_q, col_d;
    logic [YW-1:0] y_q, y_d, row_q, row_d;
    logic          bpp32_q, bpp32_d, top_down_q, top_down_d;
    logic [31:0]   file_size_q, file_size_d, img_size_q, img_size_d;
    logic [1:0]    pad_q, pad_d, padi_q, padi_d, comp_q, comp_d;
    logic [5:0]    hdr_idx_q, hdr_idx_d;
    logic [31:0]   pix_q, pix_d;
    logic          done_q, done_d, err_q, err_d;

    logic [31:0]   x_ext, y_ext, stride, height_word;
    logic [7:0]    hdr_byte;
    logic          last_comp, row_end, last_row, pad_last;

    assign x_ext       = 32'(x_q);
    assign y_ext       = 32'(y_q);
    // 3x + (x mod 4) is always a multiple of 4, so it is the padded stride
    assign stride      = bpp32_q ? (x_ext << 2) : (x_ext * 32'd3 + {30'd0, x_ext[1:0]});
    assign height_word = top_down_q ? (32'd0 - y_ext) : y_ext;
    assign last_comp   = (comp_q == (bpp32_q ? 2'd3 : 2'd2));
    assign row_end     = (col_q == x_q - X_ONE);
    assign last_row    = (row_q == y_q - Y_ONE);
    assign pad_last    = (padi_q == pad_q - 2'd1);

    ehl_bmp_hdr_mux u_hdr_mux (
        .hdr_idx   (hdr_idx_q),
        .file_size (file_size_q),
        .img_size  (img_size_q),
        .width     (x_ext),
        .height    (height_word),
        .bpp32     (bpp32_q),
        .hdr_byte  (hdr_byte)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bpp32_q     <= 1'b0;
            top_down_q  <= 1'b0;
            file_size_q <= '0;
            img_size_q  <= '0;
            pad_q       <= '0;
            padi_q      <= '0;
            comp_q      <= '0;
            hdr_idx_q   <= '0;
            pix_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bpp32_q     <= bpp32_d;
            top_down_q  <= top_down_d;
            file_size_q <= file_size_d;
            img_size_q  <= img_size_d;
            pad_q       <= pad_d;
            padi_q      <= padi_d;
            comp_q      <= comp_d;
            hdr_idx_q   <= hdr_idx_d;
            pix_q       <= pix_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and counter logic. In byte-emitting states byte_valid is
    // 1, so byte_ready alone marks a handshake.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        col_d       = col_q;
        row_d       = row_q;
        bpp32_d     = bpp32_q;
        top_down_d  = top_down_q;
        file_size_d = file_size_q;
        img_size_d  = img_size_q;
        pad_d       = pad_q;
        padi_d      = padi_q;
        comp_d      = comp_q;
        hdr_idx_d   = hdr_idx_q;
        pix_d       = pix_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (x == '0 || y == '0) begin
                        err_d = 1'b1;
                    end else begin
                        x_d        = x;
                        y_d        = y;
                        bpp32_d    = bpp32;
                        top_down_d = top_down;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                img_size_d  = stride * y_ext;
                file_size_d = 32'(HDR_LEN) + stride * y_ext;
                pad_d       = bpp32_q ? 2'd0 : x_ext[1:0];
                hdr_idx_d   = '0;
                col_d       = '0;
                row_d       = '0;
                state_d     = HDR;
            end
            HDR: begin
                if (byte_ready) begin
                    if (hdr_idx_q == HDR_LAST) state_d = PIXW;
                    else                       hdr_idx_d = hdr_idx_q + 6'd1;
                end
            end
            PIXW: begin
                if (pix_valid) begin
                    pix_d   = {pix_a, pix_r, pix_g, pix_b};
                    comp_d  = '0;
                    state_d = PIXB;
                end
            end
            PIXB: begin
                if (byte_ready) begin
                    if (!last_comp) begin
                        comp_d = comp_q + 2'd1;
                    end else if (row_end && pad_q != 2'd0) begin
                        padi_d  = '0;
                        state_d = PAD;
                    end else if (row_end && last_row) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (row_end) begin
                        col_d   = '0;
                        row_d   = row_q + Y_ONE;
                        state_d = PIXW;
                    end else begin
                        col_d   = col_q + X_ONE;
                        state_d = PIXW;
                    end
                end
            end
            PAD: begin
                if (byte_ready) begin
                    if (!pad_last) begin
                        padi_d = padi_q + 2'd1;
                    end else if (last_row) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        col_d   = '0;
                        row_d   = row_q + Y_ONE;
                        state_d = PIXW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so they hold while stalled
    always_comb begin
        busy       = (state_q != IDLE);
        pix_ready  = (state_q == PIXW);
        byte_valid = (state_q == HDR) || (state_q == PIXB) || (state_q == PAD);
        done       = done_q;
        err        = err_q;
        byte_data  = 8'd0;
        byte_last  = 1'b0;
        case (state_q)
            HDR:  byte_data = hdr_byte;
            PIXB: begin
                byte_data = byte_lane(pix_q, comp_q);
                byte_last = last_comp && row_end && last_row && (pad_q == 2'd0);
            end
            PAD:  byte_last = pad_last && last_row;
            default: byte_data = 8'd0;
        endcase
    end

endmodule
